// File: rtl/mem_bus_pkg.sv
// Shared definitions for initiators and arbiters on the 14-bit address /
// 16-bit data memory bus that fronts the mapped-register bank.
package mem_bus_pkg;

  localparam int ADDR_W = 14;
  localparam int DATA_W = 16;

  // Encoding is visible on debug outputs, so keep the numeric values fixed.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_READ  = 2'd2,
    ST_RSP   = 2'd3
  } bus_state_e;

  function automatic bit read_lat_legal(input int lat);
    return (lat >= 1) && (lat <= 15);
  endfunction

endpackage

// File: rtl/mem_bus_initiator_if.sv
// Client request/response channels plus memory-bus pins of one initiator.
// Port names are given from the initiator's point of view (i_ in, o_ out).
interface mem_bus_initiator_if
  import mem_bus_pkg::*;
#(
  parameter int AW = ADDR_W,
  parameter int DW = DATA_W
) ();

  // Both channels use valid/ready: a transfer happens on the rising edge where
  // valid and ready are both high; the sender holds valid and payload stable
  // until then, and ready may be asserted independently of valid.
  logic          i_reqValid;
  logic          o_reqReady;
  logic [AW-1:0] i_reqAddr;
  logic [DW-1:0] i_reqData;
  logic          i_reqWrite;
  logic          i_hold;

  logic          o_rspValid;
  logic [DW-1:0] o_rspData;
  logic          i_rspReady;

  logic [AW-1:0] o_memAddr;
  logic [DW-1:0] o_memDataOut;
  logic          o_memWrEn;
  logic [DW-1:0] i_memDataIn;

  modport master (
    input  i_reqValid, i_reqAddr, i_reqData, i_reqWrite, i_hold,
    output o_reqReady,
    output o_rspValid, o_rspData,
    input  i_rspReady,
    output o_memAddr, o_memDataOut, o_memWrEn,
    input  i_memDataIn
  );

  modport slave (
    output i_reqValid, i_reqAddr, i_reqData, i_reqWrite, i_hold,
    input  o_reqReady,
    input  o_rspValid, o_rspData,
    output i_rspReady,
    input  o_memAddr, o_memDataOut, o_memWrEn,
    output i_memDataIn
  );

endinterface

// File: rtl/mem_bus_initiator.sv
// Single-outstanding memory-bus initiator: one-cycle write strobe, reads
// sampled READ_LAT cycles after the address is driven, response held until taken.
module mem_bus_initiator #(
  parameter int READ_LAT = 1,
  parameter int ADDR_W   = mem_bus_pkg::ADDR_W,
  parameter int DATA_W   = mem_bus_pkg::DATA_W
) (
  input  logic                i_clk,
  input  logic                i_rstn,
  mem_bus_initiator_if.master io_bus,
  output logic                o_busy,
  output logic [1:0]          o_dbgState
);
  import mem_bus_pkg::*;

  if (!read_lat_legal(READ_LAT)) begin : g_bad_read_lat
    $error("mem_bus_initiator: READ_LAT=%0d outside 1..15", READ_LAT);
  end

  localparam logic [1:0] S_IDLE  = ST_IDLE;
  localparam logic [1:0] S_WRITE = ST_WRITE;
  localparam logic [1:0] S_READ  = ST_READ;
  localparam logic [1:0] S_RSP   = ST_RSP;

  localparam logic [3:0] LAT_LAST = 4'(READ_LAT - 1);

  logic [1:0]        r_state;
  logic [1:0]        w_state_nxt;
  logic [3:0]        r_lat_cnt;
  logic              r_write;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_mem_data;
  logic              r_rsp_valid;
  logic [DATA_W-1:0] r_rsp_data;

  logic w_req_ready;
  logic w_accept;
  logic w_lat_done;

  assign w_req_ready = (r_state == S_IDLE) & ~io_bus.i_hold;
  assign w_accept    = w_req_ready & io_bus.i_reqValid;
  assign w_lat_done  = (r_lat_cnt == LAT_LAST);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_state_nxt = io_bus.i_reqWrite ? S_WRITE : S_READ;
      S_WRITE: w_state_nxt = S_IDLE;
      S_READ:  if (w_lat_done) w_state_nxt = S_RSP;
      S_RSP:   if (io_bus.i_rspReady) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Address/data registers load only on acceptance, so the bus keeps showing
  // the last transaction between requests instead of returning to zero.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_state     <= S_IDLE;
      r_lat_cnt   <= 4'd0;
      r_write     <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_data  <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_mem_addr <= io_bus.i_reqAddr;
        r_mem_data <= io_bus.i_reqData;
        r_write    <= io_bus.i_reqWrite;
      end
      if (r_state == S_READ) begin
        if (w_lat_done) begin
          r_rsp_data  <= io_bus.i_memDataIn;
          r_rsp_valid <= 1'b1;
          r_lat_cnt   <= 4'd0;
        end else begin
          r_lat_cnt <= r_lat_cnt + 4'd1;
        end
      end
      if ((r_state == S_RSP) && io_bus.i_rspReady) begin
        r_rsp_valid <= 1'b0;
      end
    end
  end

  // Decoded straight from registers so reset drops the strobe immediately.
  assign io_bus.o_memWrEn    = (r_state == S_WRITE) & r_write;
  assign io_bus.o_memAddr    = r_mem_addr;
  assign io_bus.o_memDataOut = r_mem_data;
  assign io_bus.o_reqReady   = w_req_ready;
  assign io_bus.o_rspValid   = r_rsp_valid;
  assign io_bus.o_rspData    = r_rsp_data;

  assign o_busy     = (r_state != S_IDLE);
  assign o_dbgState = r_state;

endmodule

// File: tb/tb_mem_bus_initiator.sv
// Bench for mem_bus_initiator: two instances (READ_LAT 1 and 3) exercised in
// turn, with a response scoreboard fed by the drivers and drained by a monitor.
module tb_mem_bus_initiator;
  import mem_bus_pkg::*;

  localparam int LAT0 = 1;
  localparam int LAT1 = 3;
  localparam int AW   = ADDR_W;
  localparam int DW   = DATA_W;

  // ---------------- clock / reset ----------------
  logic clk  = 1'b0;
  logic rstn = 1'b1;
  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- per-instance signals ----------------
  logic          req_valid [2];
  logic          req_write [2];
  logic          hold      [2];
  logic          rsp_ready [2];
  logic [AW-1:0] req_addr  [2];
  logic [DW-1:0] req_data  [2];
  logic          req_ready [2];
  logic          rsp_valid [2];
  logic          mem_wr_en [2];
  logic          busy      [2];
  logic [DW-1:0] rsp_data  [2];
  logic [DW-1:0] mem_dout  [2];
  logic [DW-1:0] mem_din   [2];
  logic [AW-1:0] mem_addr  [2];
  logic [1:0]    dbg_state [2];
  logic          dir_en    [2];
  logic [DW-1:0] dir_val   [2];

  // Bus model: read data changes every cycle, so the sampled value pins down
  // exactly which cycle the initiator captured.
  function automatic logic [DW-1:0] bus_fn(input logic [AW-1:0] a, input int unsigned c);
    logic [31:0] m;
    m = c * 32'd40503;
    return DW'(a) ^ m[DW-1:0];
  endfunction

  for (genvar g = 0; g < 2; g++) begin : g_dut
    mem_bus_initiator_if bus ();
    assign bus.i_reqValid  = req_valid[g];
    assign bus.i_reqAddr   = req_addr[g];
    assign bus.i_reqData   = req_data[g];
    assign bus.i_reqWrite  = req_write[g];
    assign bus.i_hold      = hold[g];
    assign bus.i_rspReady  = rsp_ready[g];
    assign bus.i_memDataIn = mem_din[g];
    assign req_ready[g]    = bus.o_reqReady;
    assign rsp_valid[g]    = bus.o_rspValid;
    assign rsp_data[g]     = bus.o_rspData;
    assign mem_addr[g]     = bus.o_memAddr;
    assign mem_dout[g]     = bus.o_memDataOut;
    assign mem_wr_en[g]    = bus.o_memWrEn;
    assign mem_din[g]      = dir_en[g] ? dir_val[g] : bus_fn(bus.o_memAddr, cyc);

    mem_bus_initiator #(.READ_LAT((g == 0) ? LAT0 : LAT1)) u_dut (
      .i_clk      (clk),
      .i_rstn     (rstn),
      .io_bus     (bus),
      .o_busy     (busy[g]),
      .o_dbgState (dbg_state[g])
    );
  end

  // ---------------- scoreboard ----------------
  int n_vec = 0;
  int n_err = 0;
  logic [48:0] exp_q[$];   // {inst, first valid cycle, data}
  logic [AW-1:0] last_addr [2];

  task automatic chk(input string name, input int inst, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s inst%0d: got 0x%0h, expected 0x%0h (cycle %0d)", name, inst, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic chk_reset(input int inst);
    chk("rst_flags", inst, 32'({rsp_valid[inst], mem_wr_en[inst], busy[inst], dbg_state[inst]}), 0);
    chk("rst_addr", inst, 32'(mem_addr[inst]), 0);
    chk("rst_wdata", inst, 32'(mem_dout[inst]), 0);
    chk("rst_rdata", inst, 32'(rsp_data[inst]), 0);
    chk("rst_ready", inst, 32'(req_ready[inst]), 32'(!hold[inst]));
  endtask

  // Monitor: pops on the first cycle of each response, then checks stability.
  bit              in_rsp   [2] = '{0, 0};
  logic [DW-1:0]   cur_data [2];
  always @(negedge clk) begin
    logic [48:0] e;
    for (int i = 0; i < 2; i++) begin
      if (!rstn) begin
        in_rsp[i] = 0;
      end else if (rsp_valid[i]) begin
        if (!in_rsp[i]) begin
          if (exp_q.size() == 0) begin
            chk("rsp_unexpected", i, 1, 0);
          end else begin
            e = exp_q.pop_front();
            chk("rsp_inst", i, 32'(i), 32'(e[48]));
            chk("rsp_latency", i, cyc, e[47:16]);
            chk("rsp_data", i, 32'(rsp_data[i]), 32'(e[15:0]));
            cur_data[i] = e[15:0];
          end
          in_rsp[i] = 1;
        end else begin
          chk("rsp_stable", i, 32'(rsp_data[i]), 32'(cur_data[i]));
        end
      end else begin
        in_rsp[i] = 0;
      end
    end
  end

  // ---------------- drivers ----------------
  task automatic present(input int inst, input logic wr, input logic [AW-1:0] a,
                         input logic [DW-1:0] d, input int hold_cyc, output int unsigned acc);
    req_addr[inst]  = a;
    req_data[inst]  = d;
    req_write[inst] = wr;
    req_valid[inst] = 1'b1;
    for (int k = 0; k < hold_cyc; k++) begin
      hold[inst] = 1'b1;
      #1;
      chk("hold_ready_low", inst, 32'(req_ready[inst]), 0);
      step();
      chk("hold_no_accept", inst, 32'({busy[inst], mem_wr_en[inst]}), 0);
      chk("idle_addr_hold", inst, 32'(mem_addr[inst]), 32'(last_addr[inst]));
    end
    hold[inst] = 1'b0;
    #1;
    chk("idle_ready", inst, 32'(req_ready[inst]), 1);
    acc = cyc;
    step();
    req_valid[inst] = 1'b0;
    req_addr[inst]  = AW'($urandom);
    req_data[inst]  = DW'($urandom);
    req_write[inst] = 1'($urandom);
    last_addr[inst] = a;
  endtask

  task automatic do_write(input int inst, input logic [AW-1:0] a, input logic [DW-1:0] d,
                          input int hold_cyc, input bit rst_mid);
    int unsigned acc;
    present(inst, 1'b1, a, d, hold_cyc, acc);
    chk("wr_strobe", inst, 32'(mem_wr_en[inst]), 1);
    chk("wr_addr", inst, 32'(mem_addr[inst]), 32'(a));
    chk("wr_data", inst, 32'(mem_dout[inst]), 32'(d));
    chk("wr_busy_ready", inst, 32'({busy[inst], req_ready[inst]}), 32'(2'b10));
    if (rst_mid) begin
      rstn = 1'b0;
      #1;
      chk_reset(inst);
      step();
      rstn = 1'b1;
      last_addr[0] = '0;
      last_addr[1] = '0;
    end else begin
      step();
      chk("wr_done", inst, 32'({mem_wr_en[inst], busy[inst], req_ready[inst]}), 32'(3'b001));
      chk("wr_addr_held", inst, 32'(mem_addr[inst]), 32'(a));
      chk("wr_data_held", inst, 32'(mem_dout[inst]), 32'(d));
    end
  endtask

  // mode: 0 cycling bus data, 1 constant dir_val, 2 three-step 1111/2222/3333, 3 reset in RSP
  task automatic do_read(input int inst, input logic [AW-1:0] a, input int hold_cyc,
                         input int stall, input int mode);
    int          lat;
    int unsigned acc;
    logic [DW-1:0] exp_d;
    bit          done;
    int          st;
    bit          r;
    lat  = (inst == 0) ? LAT0 : LAT1;
    done = 0;
    st   = 0;
    rsp_ready[inst] = 1'b0;
    present(inst, 1'b0, a, DW'($urandom), hold_cyc, acc);
    if (mode == 1)      exp_d = dir_val[inst];
    else if (mode == 2) exp_d = 16'h3333;
    else                exp_d = bus_fn(a, acc + lat);
    exp_q.push_back({1'(inst), 32'(acc + 1 + lat), exp_d});
    for (int k = 0; k < 40 && !done; k++) begin
      if (mode == 2) begin
        dir_en[inst]  = 1'b1;
        dir_val[inst] = (k == 0) ? 16'h1111 : (k == 1) ? 16'h2222 : 16'h3333;
      end
      chk("rd_no_strobe", inst, 32'(mem_wr_en[inst]), 0);
      chk("rd_addr_stable", inst, 32'(mem_addr[inst]), 32'(a));
      if (rsp_valid[inst]) begin
        if (mode == 3) begin
          rstn = 1'b0;
          #1;
          chk_reset(inst);
          step();
          rstn = 1'b1;
          last_addr[0] = '0;
          last_addr[1] = '0;
          done = 1;
        end else if (st < stall) begin
          st++;
          rsp_ready[inst] = 1'b0;
          req_valid[inst] = 1'b1;
          #1;
          chk("rsp_blocks_req", inst, 32'({req_ready[inst], busy[inst]}), 32'(2'b01));
        end else begin
          r = (stall > 0) ? 1'b1 : 1'($urandom_range(0, 1));
          rsp_ready[inst] = r;
          req_valid[inst] = 1'b0;
          if (r) begin
            step();
            chk("rsp_done", inst, 32'({rsp_valid[inst], busy[inst], req_ready[inst]}), 32'(3'b001));
            done = 1;
          end
        end
      end else begin
        chk("rd_busy", inst, 32'(busy[inst]), 1);
        rsp_ready[inst] = (stall > 0) ? 1'b0 : 1'($urandom_range(0, 1));
      end
      if (!done) step();
    end
    if (!done) chk("rd_timeout", inst, 0, 1);
    rsp_ready[inst] = 1'b0;
    req_valid[inst] = 1'b0;
    dir_en[inst]    = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    for (int i = 0; i < 2; i++) begin
      req_valid[i] = 0; req_write[i] = 0; hold[i] = 0; rsp_ready[i] = 0;
      req_addr[i] = '0; req_data[i] = '0; dir_en[i] = 0; dir_val[i] = '0;
      last_addr[i] = '0;
    end
    #1 rstn = 1'b0;
    for (int k = 0; k < 4; k++) begin
      for (int i = 0; i < 2; i++) begin
        req_valid[i] = 1'($urandom_range(0, 1));
        req_write[i] = 1'($urandom_range(0, 1));
        req_addr[i]  = AW'($urandom);
        req_data[i]  = DW'($urandom);
        hold[i]      = (k == 3) ? 1'b0 : 1'($urandom_range(0, 1));
        rsp_ready[i] = 1'($urandom_range(0, 1));
      end
      #1;
      for (int i = 0; i < 2; i++) chk_reset(i);
      step();
    end
    for (int i = 0; i < 2; i++) begin
      req_valid[i] = 0; hold[i] = 0; rsp_ready[i] = 0;
    end
    rstn = 1'b1;
    step();
    for (int i = 0; i < 2; i++)
      chk("post_reset_idle", i, 32'({dbg_state[i], req_ready[i]}), 32'(3'b001));

    // Directed, READ_LAT = 1
    do_write(0, 14'h0024, 16'hBEEF, 0, 0);
    dir_val[0] = 16'h1234;
    dir_en[0]  = 1'b1;
    do_read(0, 14'h0004, 0, 5, 1);
    do_write(0, 14'h0abc, 16'h5a5a, 0, 0);
    do_read(0, 14'h0abc, 2, 0, 0);
    do_write(0, 14'h0100, 16'hA5A5, 1, 1);
    do_read(0, 14'h0200, 0, 0, 3);
    do_read(0, 14'h0004, 0, 0, 0);

    // Directed, READ_LAT = 3
    do_read(1, 14'h0155, 0, 0, 2);
    do_write(1, 14'h3fff, 16'hffff, 0, 0);
    do_read(1, 14'h3fff, 1, 2, 0);

    // Randomized traffic on both instances
    for (int i = 0; i < 2; i++) begin
      for (int n = 0; n < 25; n++) begin
        if ($urandom_range(0, 1) == 1)
          do_write(i, AW'($urandom), DW'($urandom), $urandom_range(0, 2), 0);
        else
          do_read(i, AW'($urandom), $urandom_range(0, 2),
                  ($urandom_range(0, 1) == 1) ? $urandom_range(1, 3) : 0, 0);
      end
    end

    step();
    step();
    chk("scoreboard_drained", 0, 32'(exp_q.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mem_bus_initiator.md
Name: mem_bus_initiator

Overview:
- Single-outstanding initiator for the 14-bit-address / 16-bit-data memory bus on which the mapped-register bank responds.
- Accepts read/write requests from a client (debug port or core load/store path) over a valid/ready handshake and drives address, write data and write enable onto the bus.
- Samples read data after a configurable latency and returns it over a valid/ready response channel.

Parameters:
- READ_LAT, 1, cycles the address is held on the bus before read data is sampled; legal range 1..15.
- ADDR_W, 14, memory bus address width.
- DATA_W, 16, memory bus data width.

Ports:
- i_clk  in  1  clock
- i_rstn  in  1  asynchronous active-low reset
- i_reqValid  in  1  client request valid
- o_reqReady  out  1  initiator can accept a request this cycle
- i_reqAddr  in  ADDR_W  request address
- i_reqData  in  DATA_W  write data; ignored for reads
- i_reqWrite  in  1  1 = write, 0 = read
- i_hold  in  1  blocks acceptance of new requests; in-flight transaction completes
- o_rspValid  out  1  read response valid
- o_rspData  out  DATA_W  read response data
- i_rspReady  in  1  client accepts response
- o_memAddr  out  ADDR_W  bus address
- o_memDataOut  out  DATA_W  bus write data
- o_memWrEn  out  1  bus write strobe
- i_memDataIn  in  DATA_W  bus read data
- o_busy  out  1  state != IDLE

Behaviour:
- One clock i_clk. Reset is asynchronous, active-low on i_rstn.
- Reset values: state IDLE, o_memAddr 0, o_memDataOut 0, o_memWrEn 0, o_rspValid 0, o_rspData 0, o_busy 0, latency counter 0.
- o_reqReady = (state==IDLE) & ~i_hold. It is combinational and does not depend on i_reqValid.
- Handshake: a request is accepted on the rising edge where i_reqValid & o_reqReady. On that edge, i_reqAddr, i_reqData and i_reqWrite are registered into o_memAddr, o_memDataOut and a write flag.
- States: IDLE, WRITE, READ, RSP.
- IDLE -> WRITE on an accepted write; IDLE -> READ on an accepted read; otherwise stay in IDLE.
- WRITE:
  - o_memWrEn=1 for exactly one cycle.
  - Next state is IDLE.
  - A new request can be accepted on the edge after WRITE, giving a throughput of one write per 2 cycles.
- READ:
  - o_memWrEn=0 and o_memAddr held stable.
  - The counter increments each cycle from 0.
  - When counter == READ_LAT-1: capture i_memDataIn into o_rspData, clear the counter, go to RSP.
- RSP:
  - o_rspValid=1 and o_rspData stable.
  - On i_rspReady: go to IDLE and clear o_rspValid on the same edge.
  - Remains in RSP indefinitely otherwise.
- Read latency: request accepted at edge t0 gives o_rspValid high in cycle t0+1+READ_LAT.
- o_memWrEn is asserted only in WRITE and never during READ/RSP/IDLE.
- Outside WRITE, o_memAddr and o_memDataOut hold the last transaction's values; no glitching to 0.
- i_hold:
  - Affects only acceptance.
  - Asserting i_hold in the same cycle as i_reqValid while IDLE means no acceptance.
  - Does not stall WRITE/READ/RSP progression.
- A request arriving while busy is not accepted. The client must hold i_reqValid and the request fields stable until accepted.
- Reset asserted mid-transaction:
  - Immediately forces the reset values, including dropping o_memWrEn.
  - The aborted transaction produces no response.
- READ_LAT outside 1..15 is illegal: elaboration-time check, synthesis error.

Decomposition:
- Shared package (mem_bus_pkg): ADDR_W/DATA_W constants and a 2-bit state enum (IDLE=0, WRITE=1, READ=2, RSP=3), reusable by future bus initiators and arbiters.
- No sub-module needed. The FSM, 4-bit latency counter and output registers live in one module.

Test Plan:
- Reset: hold i_rstn=0 with random inputs -> all outputs 0, o_reqReady=1 once i_hold=0; release -> IDLE.
- Write 0x0024 <= 0xBEEF: o_memWrEn high exactly one cycle with o_memAddr=0x0024 and o_memDataOut=0xBEEF; o_reqReady low that cycle and high the next.
- Read 0x0004, READ_LAT=1, bus returns 0x1234 -> o_rspValid in cycle t0+2 with o_rspData=0x1234; with i_rspReady held low for 5 cycles, data is stable and no new request is accepted.
- Read with READ_LAT=3, bus data changes 0x1111 -> 0x2222 -> 0x3333 across the 3 held cycles -> o_rspData=0x3333; o_memAddr stable throughout.
- Back-to-back write then read with i_hold pulsed high in IDLE -> no acceptance while i_hold=1, order preserved, o_memWrEn never high during READ.
- Assert i_rstn=0 during the WRITE cycle and during RSP -> o_memWrEn and o_rspValid drop asynchronously; after release, a fresh read returns correct data.
